// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding is compiled in only when PIPE_HAZARD_FWD_EN is defined.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_A_W = 3;
    localparam int unsigned FWD_W   = 2;

    localparam logic [FWD_W-1:0] FWD_REGFILE = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EX      = 2'b01;
    localparam logic [FWD_W-1:0] FWD_WB      = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [REG_A_W-1:0] dest;
        logic               is_load;
    } sb_slot_t;

    // EX result is younger than WB, so it wins when both hold the register.
    function automatic logic [FWD_W-1:0] fwd_encode(input logic ex_hit, input logic wb_hit);
        if (ex_hit) begin
            return FWD_EX;
        end
        if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Read-stage request and hazard-decision signals between the core and the controller.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_A_SIZE = REG_A_W
) ();

    logic [REG_A_SIZE-1:0] src1_rd;
    logic [REG_A_SIZE-1:0] src2_rd;
    logic                  src1_use;
    logic                  src2_use;
    logic [REG_A_SIZE-1:0] dest_reg_rd;
    logic                  reg_we_rd;
    logic                  mem_re_rd;
    logic                  clear;
    logic                  mem_busy;

    logic                  stall_fetch;
    logic                  stall_read;
    logic                  stall_ex;
    logic                  bubble_ex;
    logic                  flush_fetch;
    logic                  flush_read;
    logic [FWD_W-1:0]      fwd_sel1;
    logic [FWD_W-1:0]      fwd_sel2;

    modport master (
        output src1_rd, src2_rd, src1_use, src2_use, dest_reg_rd,
               reg_we_rd, mem_re_rd, clear, mem_busy,
        input  stall_fetch, stall_read, stall_ex, bubble_ex,
               flush_fetch, flush_read, fwd_sel1, fwd_sel2
    );

    modport slave (
        input  src1_rd, src2_rd, src1_use, src2_use, dest_reg_rd,
               reg_we_rd, mem_re_rd, clear, mem_busy,
        output stall_fetch, stall_read, stall_ex, bubble_ex,
               flush_fetch, flush_read, fwd_sel1, fwd_sel2
    );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Two-slot (EX, WB) in-flight write scoreboard with per-operand match outputs.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_A_SIZE = REG_A_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_hold,
    input  logic                  i_kill,
    input  logic                  i_we,
    input  logic [REG_A_SIZE-1:0] i_dest,
    input  logic                  i_load,
    input  logic [REG_A_SIZE-1:0] i_src1,
    input  logic                  i_use1,
    input  logic [REG_A_SIZE-1:0] i_src2,
    input  logic                  i_use2,
    output logic [1:0]            o_ex_alu_hit,
    output logic                  o_ex_load_hit,
    output logic [1:0]            o_wb_hit
);

    sb_slot_t r_ex;
    sb_slot_t r_wb;
    logic     w_ex_m1;
    logic     w_ex_m2;
    logic     w_unused_wb_load;

    // Slots shift EX->WB each advancing cycle; a killed or bubbled entry enters invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex <= '0;
            r_wb <= '0;
        end else if (!i_hold) begin
            r_wb <= r_ex;
            r_ex <= '{valid:   i_we & ~i_kill,
                      dest:    REG_A_W'(i_dest),
                      is_load: i_load};
        end
    end

    always_comb begin
        w_ex_m1       = i_use1 & r_ex.valid & (r_ex.dest == REG_A_W'(i_src1));
        w_ex_m2       = i_use2 & r_ex.valid & (r_ex.dest == REG_A_W'(i_src2));
        o_ex_alu_hit  = {w_ex_m2 & ~r_ex.is_load, w_ex_m1 & ~r_ex.is_load};
        o_ex_load_hit = r_ex.is_load & (w_ex_m1 | w_ex_m2);
        o_wb_hit[0]   = i_use1 & r_wb.valid & (r_wb.dest == REG_A_W'(i_src1));
        o_wb_hit[1]   = i_use2 & r_wb.valid & (r_wb.dest == REG_A_W'(i_src2));
    end

    // The WB load flag has no consumer; it rides along so the slot mirrors EX.
    assign w_unused_wb_load = r_wb.is_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Execute-stage sequencing: stall, bubble, flush and forwarding decisions.
// Define PIPE_HAZARD_FWD_EN to forward operands; otherwise every RAW hit stalls.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_A_SIZE   = REG_A_W,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
    localparam state_t           CLEAR_NXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           r_saved;
    state_t           w_saved_nxt;
    state_t           w_base;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_sf;
    logic             w_sr;
    logic             w_se;
    logic             w_bb;
    logic             w_ff;
    logic             w_fr;
    logic             w_raw_stall;
    logic [1:0]       w_ex_alu_hit;
    logic             w_ex_load_hit;
    logic [1:0]       w_wb_hit;
    logic [FWD_W-1:0] w_sel1;
    logic [FWD_W-1:0] w_sel2;

    hazard_scoreboard #(
        .REG_A_SIZE (REG_A_SIZE)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_hold        (w_se),
        .i_kill        (w_bb | w_fr),
        .i_we          (bus.reg_we_rd),
        .i_dest        (bus.dest_reg_rd),
        .i_load        (bus.mem_re_rd),
        .i_src1        (bus.src1_rd),
        .i_use1        (bus.src1_use),
        .i_src2        (bus.src2_rd),
        .i_use2        (bus.src2_use),
        .o_ex_alu_hit  (w_ex_alu_hit),
        .o_ex_load_hit (w_ex_load_hit),
        .o_wb_hit      (w_wb_hit)
    );

`ifdef PIPE_HAZARD_FWD_EN
    assign w_raw_stall = w_ex_load_hit;
    assign w_sel1      = fwd_encode(w_ex_alu_hit[0], w_wb_hit[0]);
    assign w_sel2      = fwd_encode(w_ex_alu_hit[1], w_wb_hit[1]);
`else
    assign w_raw_stall = (|w_ex_alu_hit) | w_ex_load_hit | (|w_wb_hit);
    assign w_sel1      = FWD_REGFILE;
    assign w_sel2      = FWD_REGFILE;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_saved <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_saved <= w_saved_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // HOLD only remembers where to resume; decisions are taken against that state.
    assign w_base = (r_state == HOLD) ? r_saved : r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        w_cnt_nxt   = r_cnt;
        w_sf        = 1'b0;
        w_sr        = 1'b0;
        w_se        = 1'b0;
        w_bb        = 1'b0;
        w_ff        = 1'b0;
        w_fr        = 1'b0;

        if (bus.mem_busy) begin
            w_sf        = 1'b1;
            w_sr        = 1'b1;
            w_se        = 1'b1;
            w_state_nxt = HOLD;
            w_saved_nxt = w_base;
        end else if (bus.clear) begin
            w_ff        = 1'b1;
            w_fr        = 1'b1;
            w_bb        = 1'b1;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = CLEAR_NXT;
        end else if (w_base == FLUSH) begin
            w_ff        = 1'b1;
            w_fr        = 1'b1;
            w_cnt_nxt   = r_cnt - CNT_W'(1);
            w_state_nxt = (r_cnt == CNT_W'(1)) ? RUN : FLUSH;
        end else begin
            w_state_nxt = RUN;
            if (w_raw_stall) begin
                w_sf = 1'b1;
                w_sr = 1'b1;
                w_bb = 1'b1;
            end
        end
    end

    // Outputs are forced low while reset is held, even if clear or mem_busy are driven.
    assign bus.stall_fetch = w_sf & rst;
    assign bus.stall_read  = w_sr & rst;
    assign bus.stall_ex    = w_se & rst;
    assign bus.bubble_ex   = w_bb & rst;
    assign bus.flush_fetch = w_ff & rst;
    assign bus.flush_read  = w_fr & rst;
    assign bus.fwd_sel1    = w_sel1 & {FWD_W{rst}};
    assign bus.fwd_sel2    = w_sel2 & {FWD_W{rst}};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned FC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_hazard_ctrl_if #(.REG_A_SIZE(3)) bus ();

    pipe_hazard_ctrl #(
        .REG_A_SIZE   (3),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit v;
        int d;
        bit ld;
    } ent_t;

    // Model: the two youngest issued writers and the flush cycles still owed.
    ent_t m_ex;
    ent_t m_wb;
    int   m_flush_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [9:0] dut_out();
        return {bus.stall_fetch, bus.stall_read, bus.stall_ex, bus.bubble_ex,
                bus.flush_fetch, bus.flush_read, bus.fwd_sel1, bus.fwd_sel2};
    endfunction

    function automatic int fwd_of(input int src, input bit use_it);
        if (!use_it) return 0;
        if (m_ex.v && !m_ex.ld && m_ex.d == src) return 1;
        if (m_wb.v && m_wb.d == src) return 2;
        return 0;
    endfunction

    function automatic bit reads(input ent_t e);
        return e.v && ((bus.src1_use && int'(bus.src1_rd) == e.d) ||
                       (bus.src2_use && int'(bus.src2_rd) == e.d));
    endfunction

    function automatic logic [9:0] model_out();
        bit sf = 0, sr = 0, se = 0, bb = 0, ff = 0, fr = 0, hz;
        int f1, f2;
`ifdef PIPE_HAZARD_FWD_EN
        f1 = fwd_of(int'(bus.src1_rd), bus.src1_use);
        f2 = fwd_of(int'(bus.src2_rd), bus.src2_use);
        hz = reads(m_ex) && m_ex.ld;
`else
        f1 = 0;
        f2 = 0;
        hz = reads(m_ex) || reads(m_wb);
`endif
        if (bus.mem_busy) begin
            sf = 1; sr = 1; se = 1;
        end else if (bus.clear) begin
            ff = 1; fr = 1; bb = 1;
        end else if (m_flush_left > 0) begin
            ff = 1; fr = 1;
        end else if (hz) begin
            sf = 1; sr = 1; bb = 1;
        end
        return {sf, sr, se, bb, ff, fr, 2'(f1), 2'(f2)};
    endfunction

    task automatic model_step(input logic [9:0] o);
        if (bus.mem_busy) return;
        if (bus.clear) m_flush_left = int'(FC) - 1;
        else if (m_flush_left > 0) m_flush_left--;
        m_wb    = m_ex;
        m_ex.v  = bus.reg_we_rd && !o[6] && !o[4];
        m_ex.d  = int'(bus.dest_reg_rd);
        m_ex.ld = bus.mem_re_rd;
    endtask

    // Single compare process: checks every cycle, then advances the model for the coming edge.
    always begin
        @(negedge clk);
        if (!rst) begin
            m_ex = '{0, 0, 0};
            m_wb = '{0, 0, 0};
            m_flush_left = 0;
            chk("outputs_in_reset", 32'(dut_out()), 32'd0);
        end else begin
            logic [9:0] e;
            e = model_out();
            chk("outputs_vs_model", 32'(dut_out()), 32'(e));
            model_step(e);
        end
    end

    task automatic cyc(input bit we, input int dest, input bit ld,
                       input int s1, input bit u1, input int s2, input bit u2,
                       input bit clr, input bit busy);
        @(posedge clk);
        #1;
        bus.reg_we_rd   = we;
        bus.dest_reg_rd = 3'(dest);
        bus.mem_re_rd   = ld;
        bus.src1_rd     = 3'(s1);
        bus.src1_use    = u1;
        bus.src2_rd     = 3'(s2);
        bus.src2_use    = u2;
        bus.clear       = clr;
        bus.mem_busy    = busy;
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit busy_prev;
        bus.reg_we_rd = 0; bus.dest_reg_rd = 0; bus.mem_re_rd = 0;
        bus.src1_rd = 0; bus.src1_use = 0; bus.src2_rd = 0; bus.src2_use = 0;
        bus.clear = 1; bus.mem_busy = 1;
        #12;
        chk("reset_outputs_zero", 32'(dut_out()), 32'd0);
        bus.clear = 0; bus.mem_busy = 0;
        @(posedge clk); #1 rst = 1;
        nops(2);

        // Back-to-back dependent ALU ops
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 2, 0, 1, 1, 3, 1, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
        chk("b2b_fwd_sel1", 32'(bus.fwd_sel1), 32'd1);
        chk("b2b_no_stall", 32'(bus.stall_fetch), 32'd0);
`else
        chk("b2b_stall", 32'({bus.stall_fetch, bus.bubble_ex}), 32'd3);
        chk("b2b_sel1", 32'(bus.fwd_sel1), 32'd0);
`endif
        nops(3);

        // One NOP between writer and reader
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        nops(1);
        cyc(1, 2, 0, 1, 1, 3, 1, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
        chk("gap_fwd_sel1", 32'(bus.fwd_sel1), 32'd2);
        chk("gap_no_stall", 32'(bus.stall_fetch), 32'd0);
`else
        chk("gap_stall", 32'(bus.stall_fetch), 32'd1);
`endif
        nops(3);

        // Load-use
        cyc(1, 4, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, 4, 1, 4, 1, 0, 0);
        chk("lu_stall", 32'({bus.stall_fetch, bus.stall_read, bus.stall_ex, bus.bubble_ex}), 32'hD);
        cyc(1, 5, 0, 4, 1, 4, 1, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
        chk("lu_fwd_sels", 32'({bus.fwd_sel1, bus.fwd_sel2}), 32'hA);
        chk("lu_released", 32'(bus.stall_fetch), 32'd0);
`else
        chk("lu_stall2", 32'(bus.stall_fetch), 32'd1);
        cyc(1, 5, 0, 4, 1, 4, 1, 0, 0);
        chk("lu_released", 32'({bus.stall_fetch, bus.fwd_sel1, bus.fwd_sel2}), 32'd0);
`endif
        nops(3);

        // Jump flush and no false forwarding afterwards
        cyc(1, 7, 0, 0, 0, 0, 0, 1, 0);
        chk("clr_first", 32'({bus.flush_fetch, bus.flush_read, bus.bubble_ex}), 32'd7);
        cyc(1, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("clr_second", 32'({bus.flush_fetch, bus.flush_read, bus.bubble_ex}), 32'd6);
        cyc(1, 3, 0, 7, 1, 7, 1, 0, 0);
        chk("clr_done", 32'(dut_out()), 32'd0);
        nops(3);

        // Clear beats load-use; mem_busy freezes the flush
        cyc(1, 4, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, 4, 1, 4, 1, 1, 0);
        chk("clr_over_lu", 32'({bus.flush_fetch, bus.stall_fetch, bus.bubble_ex}), 32'd5);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
            chk("hold_in_flush", 32'({bus.stall_ex, bus.flush_fetch}), 32'd2);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_resume", 32'(bus.flush_fetch), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_end", 32'(bus.flush_fetch), 32'd0);
        nops(3);

        // r6 in both EX and WB
        cyc(1, 6, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 6, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, 6, 1, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
        chk("ex_beats_wb", 32'(bus.fwd_sel1), 32'd1);
`else
        chk("dual_stall", 32'(bus.stall_fetch), 32'd1);
`endif
        nops(3);
        cyc(1, 6, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 6, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, 6, 0, 0, 0, 0, 0);
        chk("unused_src", 32'({bus.fwd_sel1, bus.stall_fetch}), 32'd0);
        nops(3);

        // Asynchronous reset in the middle of a flush
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_reset_flush", 32'(bus.flush_fetch), 32'd1);
        #1 rst = 0;
        #1 chk("async_reset", 32'(dut_out()), 32'd0);
        @(posedge clk); #1 rst = 1;
        cyc(1, 2, 0, 1, 1, 1, 1, 0, 0);
        chk("post_reset_dep", 32'({bus.fwd_sel1, bus.fwd_sel2, bus.stall_fetch}), 32'd0);
        nops(2);

        // Random traffic
        busy_prev = 0;
        for (int n = 0; n < 3000; n++) begin
            bit busy;
            busy = busy_prev ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            busy_prev = busy;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 2) == 0,
                $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                $urandom_range(0, 7), $urandom_range(0, 1) == 0,
                $urandom_range(0, 9) == 0, busy);
            if ($urandom_range(0, 399) == 0) begin
                #1 rst = 0;
                @(posedge clk); #1 rst = 1;
            end
        end
        nops(2);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
